// File: rtl/serial_matmul_mem_responder_if.sv
// Request/response bundle between serial_matmul (master) and its memory responder (slave).
// Member names keep the responder-relative _i/_o suffixes so they map one-to-one onto the port list.
interface serial_matmul_mem_responder_if;
    logic        mem_req_valid_i;
    logic        mem_req_ready_o;
    logic [4:0]  mem_req_cmd_i;
    logic [2:0]  mem_req_typ_i;
    logic [39:0] mem_req_addr_i;
    logic [63:0] mem_req_data_i;
    logic        mem_resp_valid_o;
    logic [4:0]  mem_resp_cmd_o;
    logic [2:0]  mem_resp_typ_o;
    logic [39:0] mem_resp_addr_o;
    logic [63:0] mem_resp_data_o;

    modport master (
        output mem_req_valid_i, mem_req_cmd_i, mem_req_typ_i, mem_req_addr_i, mem_req_data_i,
        input  mem_req_ready_o,
        input  mem_resp_valid_o, mem_resp_cmd_o, mem_resp_typ_o, mem_resp_addr_o, mem_resp_data_o
    );

    modport slave (
        input  mem_req_valid_i, mem_req_cmd_i, mem_req_typ_i, mem_req_addr_i, mem_req_data_i,
        output mem_req_ready_o,
        output mem_resp_valid_o, mem_resp_cmd_o, mem_resp_typ_o, mem_resp_addr_o, mem_resp_data_o
    );
endinterface

// File: rtl/serial_matmul_mem_responder.sv
// Single-outstanding 64b word-addressed memory responder with fixed response latency.
// Define SERIAL_MATMUL_MEM_RAND_DELAY_EN to stretch each latency by 0..7 cycles from an 8b LFSR.
module serial_matmul_mem_responder #(
    parameter int NWORDS  = 256,
    parameter int LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    serial_matmul_mem_responder_if.slave bus
);
    localparam int AW = $clog2(NWORDS);
    localparam int CW = $clog2(LATENCY + 8) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    cmd_q, cmd_d;
    logic [2:0]    typ_q, typ_d;
    logic [39:0]   addr_q, addr_d;
    logic [63:0]   data_q, data_d;
    logic [63:0]   mem_q [NWORDS];

    logic          wr_en;
    logic [AW-1:0] word_idx;
    logic [2:0]    off;
    logic [7:0]    byte_mask;
    logic [63:0]   bit_mask, cur_word, wr_word, rd_shift, rd_ext;
    logic [2:0]    extra_dly;

`ifdef SERIAL_MATMUL_MEM_RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;

    // x^8+x^6+x^5+x^4+1, stepped once per accepted request
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == IDLE && bus.mem_req_valid_i)
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end

    assign extra_dly = lfsr_q[2:0];
`else
    assign extra_dly = 3'd0;
`endif

    // Byte lane selection: offset is forced to the natural alignment of the access size
    always_comb begin
        word_idx = bus.mem_req_addr_i[AW+2:3];
        cur_word = mem_q[word_idx];
        case (bus.mem_req_typ_i)
            3'd0, 3'd4: begin off = bus.mem_req_addr_i[2:0];         byte_mask = 8'h01; end
            3'd1, 3'd5: begin off = {bus.mem_req_addr_i[2:1], 1'b0}; byte_mask = 8'h03; end
            3'd2, 3'd6: begin off = {bus.mem_req_addr_i[2], 2'b00};  byte_mask = 8'h0F; end
            default:    begin off = 3'd0;                            byte_mask = 8'hFF; end
        endcase
        byte_mask = byte_mask << off;
        for (int i = 0; i < 8; i++)
            bit_mask[8*i +: 8] = {8{byte_mask[i]}};
        wr_word  = (cur_word & ~bit_mask) | ((bus.mem_req_data_i << {off, 3'b000}) & bit_mask);
        rd_shift = cur_word >> {off, 3'b000};
        case (bus.mem_req_typ_i)
            3'd0:    rd_ext = {{56{rd_shift[7]}},  rd_shift[7:0]};
            3'd1:    rd_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'd2:    rd_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'd4:    rd_ext = {56'd0, rd_shift[7:0]};
            3'd5:    rd_ext = {48'd0, rd_shift[15:0]};
            3'd6:    rd_ext = {32'd0, rd_shift[31:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        typ_d   = typ_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_req_valid_i) begin
                    cmd_d   = bus.mem_req_cmd_i;
                    typ_d   = bus.mem_req_typ_i;
                    addr_d  = bus.mem_req_addr_i;
                    data_d  = (bus.mem_req_cmd_i == 5'h00) ? rd_ext : 64'd0;
                    wr_en   = (bus.mem_req_cmd_i == 5'h01);
                    cnt_d   = CW'(LATENCY - 1) + CW'(extra_dly);
                    state_d = (cnt_d == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            typ_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            typ_q   <= typ_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Array is deliberately left out of reset so contents survive a mid-transaction reset
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem_q[word_idx] <= wr_word;
    end

    assign bus.mem_req_ready_o  = (state_q == IDLE);
    assign bus.mem_resp_valid_o = (state_q == RESP);
    assign bus.mem_resp_cmd_o   = cmd_q;
    assign bus.mem_resp_typ_o   = typ_q;
    assign bus.mem_resp_addr_o  = addr_q;
    assign bus.mem_resp_data_o  = data_q;
endmodule

// File: tb/tb_serial_matmul_mem_responder.sv
// Self-checking bench for serial_matmul_mem_responder: directed cases plus randomized traffic
// compared against a byte-array memory model.
module tb_serial_matmul_mem_responder;
    localparam int NW   = 256;
    localparam int LAT  = 2;
    localparam int LAT4 = 4;
`ifdef SERIAL_MATMUL_MEM_RAND_DELAY_EN
    localparam int XTRA = 7;
`else
    localparam int XTRA = 0;
`endif

    typedef struct {
        bit          ok;
        int          lat;
        logic        ready_after;
        logic        valid_after;
        logic [4:0]  cmd;
        logic [2:0]  typ;
        logic [39:0] addr;
        logic [63:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] ref_mem [NW*8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_matmul_mem_responder_if bus ();
    serial_matmul_mem_responder_if bus4 ();

    serial_matmul_mem_responder #(.NWORDS(NW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    serial_matmul_mem_responder #(.NWORDS(NW), .LATENCY(LAT4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4));

    function automatic int size_of(input logic [2:0] typ);
        case (typ)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            default:    return 8;
        endcase
    endfunction

    function automatic void model_store(input logic [39:0] addr, input logic [2:0] typ, input logic [63:0] data);
        int sz, word, off;
        sz   = size_of(typ);
        word = int'((addr / 8) % NW);
        off  = int'(addr % 8);
        off  = off - (off % sz);
        for (int i = 0; i < sz; i++) ref_mem[word*8 + off + i] = data[8*i +: 8];
    endfunction

    function automatic logic [63:0] model_load(input logic [39:0] addr, input logic [2:0] typ);
        int sz, word, off;
        logic [63:0] v;
        sz   = size_of(typ);
        word = int'((addr / 8) % NW);
        off  = int'(addr % 8);
        off  = off - (off % sz);
        v    = 64'd0;
        for (int i = 0; i < sz; i++) v = v | (64'(ref_mem[word*8 + off + i]) << (8*i));
        if (typ <= 3'd2 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
        return v;
    endfunction

    task automatic issue(input logic [4:0] cmd, input logic [2:0] typ, input logic [39:0] addr,
                         input logic [63:0] data, output resp_t r);
        int n, t;
        r = '{ok: 1'b1, lat: 0, ready_after: 1'b0, valid_after: 1'b0, cmd: '0, typ: '0, addr: '0, data: '0};
        @(negedge clk);
        bus.mem_req_valid_i = 1'b1;
        bus.mem_req_cmd_i   = cmd;
        bus.mem_req_typ_i   = typ;
        bus.mem_req_addr_i  = addr;
        bus.mem_req_data_i  = data;
        n = 0;
        while (!bus.mem_req_ready_o && n < 50) begin @(negedge clk); n++; end
        if (!bus.mem_req_ready_o) begin r.ok = 1'b0; bus.mem_req_valid_i = 1'b0; return; end
        t = cyc;
        @(negedge clk);
        bus.mem_req_valid_i = 1'b0;
        r.ready_after = bus.mem_req_ready_o;
        n = 0;
        while (!bus.mem_resp_valid_o && n < 40) begin @(negedge clk); n++; end
        if (!bus.mem_resp_valid_o) begin r.ok = 1'b0; return; end
        r.lat  = cyc - t;
        r.cmd  = bus.mem_resp_cmd_o;
        r.typ  = bus.mem_resp_typ_o;
        r.addr = bus.mem_resp_addr_o;
        r.data = bus.mem_resp_data_o;
        @(negedge clk);
        r.valid_after = bus.mem_resp_valid_o;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_req_ready_o !== 1'b1 || bus.mem_resp_valid_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_idle cyc%0d: ready=%b valid=%b expected ready=1 valid=0",
                         i, bus.mem_req_ready_o, bus.mem_resp_valid_o);
            end
        end
        checks++;
        if ({bus.mem_resp_cmd_o, bus.mem_resp_typ_o, bus.mem_resp_addr_o, bus.mem_resp_data_o} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_fields: cmd=%h typ=%h addr=%h data=%h expected all 0",
                     bus.mem_resp_cmd_o, bus.mem_resp_typ_o, bus.mem_resp_addr_o, bus.mem_resp_data_o);
        end
    endtask

    task automatic test_store_load_d();
        resp_t r;
        issue(5'h01, 3'd3, 40'h10, 64'h0123_4567_89AB_CDEF, r);
        model_store(40'h10, 3'd3, 64'h0123_4567_89AB_CDEF);
        checks++;
        if (!r.ok || r.data !== 64'd0 || r.lat < LAT || r.lat > LAT + XTRA || r.cmd !== 5'h01) begin
            failures++;
            $display("[TB] FAIL store_d: ok=%0b lat=%0d data=%h cmd=%h expected lat=%0d..%0d data=0 cmd=01",
                     r.ok, r.lat, r.data, r.cmd, LAT, LAT + XTRA);
        end
        checks++;
        if (r.ready_after !== 1'b0 || r.valid_after !== 1'b0) begin
            failures++;
            $display("[TB] FAIL store_d_handshake: ready_after=%b valid_after=%b expected 0 0",
                     r.ready_after, r.valid_after);
        end
        issue(5'h00, 3'd3, 40'h10, 64'd0, r);
        checks++;
        if (!r.ok || r.data !== 64'h0123_4567_89AB_CDEF || r.addr !== 40'h10 || r.typ !== 3'd3) begin
            failures++;
            $display("[TB] FAIL load_d: ok=%0b data=%h addr=%h typ=%0d expected 0123456789abcdef 10 3",
                     r.ok, r.data, r.addr, r.typ);
        end
    endtask

    task automatic test_byte_ops();
        resp_t r;
        logic [2:0]  typs [3] = '{3'd0, 3'd4, 3'd2};
        logic [39:0] adrs [3] = '{40'h13, 40'h13, 40'h10};
        logic [63:0] exps [3] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_00F0, 64'hFFFF_FFFF_F0AB_CDEF};
        issue(5'h01, 3'd0, 40'h13, 64'hF0, r);
        model_store(40'h13, 3'd0, 64'hF0);
        for (int i = 0; i < 3; i++) begin
            issue(5'h00, typs[i], adrs[i], 64'd0, r);
            checks++;
            if (!r.ok || r.data !== exps[i]) begin
                failures++;
                $display("[TB] FAIL byte_load%0d typ=%0d: ok=%0b data=%h expected %h",
                         i, typs[i], r.ok, r.data, exps[i]);
            end
        end
    endtask

    task automatic test_wrap();
        resp_t r;
        issue(5'h01, 3'd3, 40'(NW*8 + 8), 64'h55, r);
        model_store(40'(NW*8 + 8), 3'd3, 64'h55);
        issue(5'h00, 3'd3, 40'h08, 64'd0, r);
        checks++;
        if (!r.ok || r.data !== 64'h55) begin
            failures++;
            $display("[TB] FAIL addr_wrap: ok=%0b data=%h expected 55", r.ok, r.data);
        end
    endtask

    task automatic test_random();
        resp_t r;
        logic [4:0]  cmd;
        logic [2:0]  typ;
        logic [39:0] addr;
        logic [63:0] data, exp;
        int sel;
        for (int w = 0; w < 16; w++) begin
            data = {$urandom, $urandom};
            issue(5'h01, 3'd3, 40'(w*8), data, r);
            model_store(40'(w*8), 3'd3, data);
        end
        for (int i = 0; i < 80; i++) begin
            sel  = $urandom_range(0, 9);
            cmd  = (sel < 4) ? 5'h00 : (sel < 8) ? 5'h01 : 5'($urandom_range(2, 31));
            typ  = 3'($urandom_range(0, 7));
            addr = {29'($urandom), 8'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
            data = {$urandom, $urandom};
            exp  = (cmd == 5'h00) ? model_load(addr, typ) : 64'd0;
            issue(cmd, typ, addr, data, r);
            if (cmd == 5'h01) model_store(addr, typ, data);
            checks++;
            if (!r.ok || r.data !== exp || r.cmd !== cmd || r.typ !== typ || r.addr !== addr) begin
                failures++;
                $display("[TB] FAIL rand%0d: ok=%0b cmd=%h typ=%0d addr=%h data=%h expected cmd=%h typ=%0d addr=%h data=%h",
                         i, r.ok, r.cmd, r.typ, r.addr, r.data, cmd, typ, addr, exp);
            end
            checks++;
            if (r.lat < LAT || r.lat > LAT + XTRA || r.valid_after !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rand%0d_timing: lat=%0d valid_after=%b expected lat=%0d..%0d valid_after=0",
                         i, r.lat, r.valid_after, LAT, LAT + XTRA);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, n;
        bit acc2, drop;
        int   rcyc [$];
        logic [63:0] rdat [$];
        logic [63:0] val;
        val = {$urandom, $urandom};
        @(negedge clk);
        bus.mem_req_valid_i = 1'b1;
        bus.mem_req_cmd_i   = 5'h01;
        bus.mem_req_typ_i   = 3'd3;
        bus.mem_req_addr_i  = 40'h40;
        bus.mem_req_data_i  = val;
        n = 0;
        while (!bus.mem_req_ready_o && n < 50) begin @(negedge clk); n++; end
        t1 = cyc;
        @(negedge clk);
        checks++;
        if (bus.mem_req_ready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_ready_drop: ready=%b expected 0", bus.mem_req_ready_o);
        end
        bus.mem_req_cmd_i  = 5'h00;
        bus.mem_req_data_i = 64'd0;
        acc2 = 1'b0; drop = 1'b0; t2 = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus.mem_resp_valid_o) begin rcyc.push_back(cyc); rdat.push_back(bus.mem_resp_data_o); end
            if (drop) begin bus.mem_req_valid_i = 1'b0; drop = 1'b0; end
            if (bus.mem_req_ready_o && bus.mem_req_valid_i && !acc2) begin acc2 = 1'b1; t2 = cyc; drop = 1'b1; end
            @(negedge clk);
        end
        bus.mem_req_valid_i = 1'b0;
        checks++;
        if (rcyc.size() != 2) begin
            failures++;
            $display("[TB] FAIL b2b_resp_count: got %0d expected 2", rcyc.size());
        end else begin
            checks++;
            if (rdat[0] !== 64'd0 || rdat[1] !== val) begin
                failures++;
                $display("[TB] FAIL b2b_order: data0=%h data1=%h expected 0 %h", rdat[0], rdat[1], val);
            end
            checks++;
            if (t2 != rcyc[0] + 1 || (XTRA == 0 && t2 != t1 + LAT + 1)) begin
                failures++;
                $display("[TB] FAIL b2b_second_accept: cycle=%0d expected %0d (first accept %0d)",
                         t2, rcyc[0] + 1, t1);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int n, t, seen;
        logic [63:0] val;
        val = {$urandom, $urandom};
        @(negedge clk);
        bus4.mem_req_valid_i = 1'b1;
        bus4.mem_req_cmd_i   = 5'h01;
        bus4.mem_req_typ_i   = 3'd3;
        bus4.mem_req_addr_i  = 40'h20;
        bus4.mem_req_data_i  = val;
        n = 0;
        while (!bus4.mem_req_ready_o && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus4.mem_req_valid_i = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (bus4.mem_resp_valid_o) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || bus4.mem_req_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_wait_drop: pulses=%0d ready=%b expected 0 1", seen, bus4.mem_req_ready_o);
        end
        bus4.mem_req_valid_i = 1'b1;
        bus4.mem_req_cmd_i   = 5'h00;
        bus4.mem_req_data_i  = 64'd0;
        t = cyc;
        @(negedge clk);
        bus4.mem_req_valid_i = 1'b0;
        n = 0;
        while (!bus4.mem_resp_valid_o && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (!bus4.mem_resp_valid_o || bus4.mem_resp_data_o !== val
            || cyc - t < LAT4 || cyc - t > LAT4 + XTRA) begin
            failures++;
            $display("[TB] FAIL reset_wait_reload: valid=%b data=%h lat=%0d expected 1 %h lat=%0d..%0d",
                     bus4.mem_resp_valid_o, bus4.mem_resp_data_o, cyc - t, val, LAT4, LAT4 + XTRA);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.mem_req_valid_i  = 1'b0;
        bus.mem_req_cmd_i    = '0;
        bus.mem_req_typ_i    = '0;
        bus.mem_req_addr_i   = '0;
        bus.mem_req_data_i   = '0;
        bus4.mem_req_valid_i = 1'b0;
        bus4.mem_req_cmd_i   = '0;
        bus4.mem_req_typ_i   = '0;
        bus4.mem_req_addr_i  = '0;
        bus4.mem_req_data_i  = '0;
        test_reset();
        test_store_load_d();
        test_byte_ops();
        test_wrap();
        test_random();
        test_back_to_back();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
